ibex_instr_bus_responder: RTL and testbench
===========================================

IBEX_INSTR_BUS_RESPONDER -- requirements
Module: ibex_instr_bus_responder

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- AddrBase, 32'h0010_0000: first byte address served; aligned to AddrSize.
- AddrSize, 32'h0001_0000: bytes served; power of two, at least 4.
- MaxOutstanding, 2: granted-but-unanswered requests allowed; range 1..4.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning. It SHALL use one clock; reset is synchronous and active-high.
- clk_i, in, 1: clock; all state updates on the rising edge.
- rst_i, in, 1: synchronous active-high reset.
- instr_req_i, in, 1: fetch request from the core.
- instr_addr_i, in, 32: fetch byte address.
- instr_gnt_o, out, 1: request accepted this cycle.
- instr_rvalid_o, out, 1: response valid.
- instr_rdata_o, out, 32: response data.
- instr_err_o, out, 1: response is an error; qualified by instr_rvalid_o.
- gnt_stall_i, in, 1: suppresses grant (test/back-pressure hook).
- rsp_stall_i, in, 1: suppresses response issue.
- mem_req_o, out, 1: SRAM read strobe.
- mem_addr_o, out, log2(AddrSize)-2: SRAM word index.
- mem_rdata_i, in, 32: SRAM read data, valid one cycle after mem_req_o.
- outstanding_o, out, 3: current outstanding count.
- busy_o, out, 1: outstanding_o != 0.

Function
REQ-003 instr_gnt_o SHALL equal instr_req_i & ~gnt_stall_i & (outstanding_o < MaxOutstanding), combinationally; it SHALL NOT depend on instr_rvalid_o.
REQ-004 A granted address SHALL be legal iff AddrBase <= addr < AddrBase+AddrSize and addr[1:0]==0.
REQ-005 The upper-bound comparison SHALL be done at 33 bits so that AddrBase+AddrSize never wraps.
REQ-006 A legal grant SHALL assert mem_req_o in the same cycle, with mem_addr_o = (addr-AddrBase)>>2.
REQ-007 An illegal grant, or any cycle without a grant, SHALL hold mem_req_o low.
REQ-008 In the cycle after a grant, stage S1 SHALL hold {rdata, err}: mem_rdata_i with err=0 for a legal grant, 32'h0 with err=1 for an illegal grant.
REQ-009 Response source SHALL be the FIFO head if the FIFO is non-empty, else S1.
REQ-010 instr_rvalid_o SHALL equal (source valid) & ~rsp_stall_i.
REQ-011 Minimum grant-to-rvalid latency SHALL be exactly 1 cycle.
REQ-012 An S1 entry that is not issued that cycle SHALL be pushed into a MaxOutstanding-deep FIFO.
REQ-013 When the head pops while S1 is valid, S1 SHALL still be pushed in the same cycle.
REQ-014 Responses SHALL return in strict grant order; no entry SHALL be dropped or duplicated.
REQ-015 outstanding_o SHALL be +1 on grant only, -1 on rvalid only, and unchanged when both occur in the same cycle.
REQ-016 The FIFO SHALL never overflow; REQ-003 guarantees this.
REQ-017 When instr_rvalid_o is 0, instr_rdata_o and instr_err_o SHALL be 0.
REQ-018 Grant and response SHALL proceed concurrently; at MaxOutstanding a same-cycle response does NOT free a grant slot until the next cycle.

Reset
REQ-019 While rst_i=1, outputs SHALL be: instr_gnt_o=0, instr_rvalid_o=0, instr_rdata_o=0, instr_err_o=0, mem_req_o=0, mem_addr_o=0, outstanding_o=0, busy_o=0.
REQ-020 Reset asserted mid-operation SHALL discard S1, FIFO contents and counters, so that no response for a pre-reset grant appears after reset.
REQ-021 Grants SHALL resume in the first cycle after rst_i deasserts.

Verification
REQ-022 Single legal fetch: addr 32'h0010_0008 granted in cycle T, mem_rdata_i=32'hDEAD_BEEF -> mem_addr_o=2 in T; rvalid=1, rdata=32'hDEAD_BEEF, err=0 in T+1.
REQ-023 Illegal fetches: addr 32'h0011_0000, then 32'h0010_0002 -> both granted with mem_req_o=0; rvalid one cycle later with err=1, rdata=0.
REQ-024 Back-pressure: rsp_stall_i=1 with requests held continuously -> exactly 2 grants, then instr_gnt_o=0 and outstanding_o=2. Release stall -> responses return in order on consecutive cycles; grants resume the cycle after the first pop.
REQ-025 Streaming: continuous requests with no stalls -> one grant and one rvalid every cycle; outstanding_o stays at 1; data matches the address sequence.
REQ-026 Reset mid-flight: 2 outstanding, rst_i pulsed for 1 cycle -> zero rvalids afterwards; outstanding_o=0; a new fetch completes with 1-cycle latency.
REQ-027 Top-of-range boundary: addr AddrBase+AddrSize-4 -> legal, with mem_addr_o all ones.

Source files
------------

// File: rtl/ibex_instr_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : ibex_instr_bus_responder
//  Description : Instruction-bus slave for an Ibex-style fetch port. Grants
//                fetches while fewer than MaxOutstanding are pending, reads a
//                single-cycle SRAM for in-range aligned addresses, flags the
//                rest as bus errors, and returns responses in grant order
//                through a one-entry stage (S1) backed by a small FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module ibex_instr_bus_responder #(
  parameter logic [31:0] AddrBase       = 32'h0010_0000,
  parameter logic [31:0] AddrSize       = 32'h0001_0000,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           instr_req_i,
  input  logic [31:0]                    instr_addr_i,
  output logic                           instr_gnt_o,
  output logic                           instr_rvalid_o,
  output logic [31:0]                    instr_rdata_o,
  output logic                           instr_err_o,
  input  logic                           gnt_stall_i,
  input  logic                           rsp_stall_i,
  output logic                           mem_req_o,
  output logic [$clog2(AddrSize)-3:0]    mem_addr_o,
  input  logic [31:0]                    mem_rdata_i,
  output logic [2:0]                     outstanding_o,
  output logic                           busy_o
);

  localparam int unsigned c_MEM_AW  = $clog2(AddrSize) - 2;
  localparam logic [2:0]  c_MAX_OUT = 3'(MaxOutstanding);
  localparam logic [1:0]  c_MAX_PTR = 2'(MaxOutstanding - 1);
  localparam logic [32:0] c_LO      = {1'b0, AddrBase};
  localparam logic [32:0] c_HI      = {1'b0, AddrBase} + {1'b0, AddrSize};

  // Pending-response bookkeeping
  logic [2:0]  outstanding_q, outstanding_d;
  logic        s1_valid_q, s1_valid_d;
  logic        s1_err_q, s1_err_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]  fifo_cnt_q, fifo_cnt_d;
  // FIFO entries are {err, rdata}; sized for the largest legal depth
  logic [32:0] fifo_q [4];

  logic [32:0] w_a33;
  logic        w_legal;
  logic        w_gnt;
  logic [31:0] w_offset;
  logic [31:0] w_s1_rdata;
  logic        w_fifo_empty;
  logic [32:0] w_src;
  logic        w_src_valid;
  logic        w_rvalid;
  logic        w_push;
  logic        w_pop;
  logic        unused_offset;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    ptr_inc = (p == c_MAX_PTR) ? 2'd0 : p + 2'd1;
  endfunction

  // Address decode, grant and SRAM strobe (all combinational on the request)
  always_comb begin
    w_a33    = {1'b0, instr_addr_i};
    // 33-bit compare so AddrBase+AddrSize can reach 2^32 without wrapping
    w_legal  = (w_a33 >= c_LO) && (w_a33 < c_HI) && (instr_addr_i[1:0] == 2'b00);
    w_gnt    = ~rst_i & instr_req_i & ~gnt_stall_i & (outstanding_q < c_MAX_OUT);
    w_offset = instr_addr_i - AddrBase;
  end

  assign unused_offset = ^{w_offset[31:c_MEM_AW+2], w_offset[1:0]};

  assign instr_gnt_o = w_gnt;
  assign mem_req_o   = w_gnt & w_legal;
  assign mem_addr_o  = mem_req_o ? w_offset[c_MEM_AW+1:2] : '0;

  // Response selection: oldest FIFO entry wins, otherwise the S1 stage
  always_comb begin
    // SRAM data arrives the cycle after the strobe, i.e. while S1 holds it
    w_s1_rdata   = s1_err_q ? 32'h0 : mem_rdata_i;
    w_fifo_empty = (fifo_cnt_q == 3'd0);
    w_src        = w_fifo_empty ? {s1_err_q, w_s1_rdata} : fifo_q[rd_ptr_q];
    w_src_valid  = w_fifo_empty ? s1_valid_q : 1'b1;
    w_rvalid     = ~rst_i & w_src_valid & ~rsp_stall_i;
    w_pop        = w_rvalid & ~w_fifo_empty;
    // S1 is parked in the FIFO unless it went straight out this cycle
    w_push       = s1_valid_q & ~(w_rvalid & w_fifo_empty);
  end

  assign instr_rvalid_o = w_rvalid;
  assign instr_rdata_o  = w_rvalid ? w_src[31:0] : 32'h0;
  assign instr_err_o    = w_rvalid ? w_src[32] : 1'b0;
  assign outstanding_o  = rst_i ? 3'd0 : outstanding_q;
  assign busy_o         = ~rst_i & (outstanding_q != 3'd0);

  // Next-state for S1, FIFO pointers/count and the outstanding counter
  always_comb begin
    s1_valid_d    = w_gnt;
    s1_err_d      = ~w_legal;
    rd_ptr_d      = w_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d      = w_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    fifo_cnt_d    = fifo_cnt_q;
    outstanding_d = outstanding_q;
    case ({w_push, w_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    case ({w_gnt, w_rvalid})
      2'b10:   outstanding_d = outstanding_q + 3'd1;
      2'b01:   outstanding_d = outstanding_q - 3'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // State registers; reset discards every in-flight response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q    <= 1'b0;
      s1_err_q      <= 1'b0;
      rd_ptr_q      <= 2'd0;
      wr_ptr_q      <= 2'd0;
      fifo_cnt_q    <= 3'd0;
      outstanding_q <= 3'd0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_err_q      <= s1_err_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      outstanding_q <= outstanding_d;
    end
  end

  // FIFO storage; contents are don't-care once the count is cleared
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      fifo_q[wr_ptr_q] <= {s1_err_q, w_s1_rdata};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ibex_instr_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ibex_instr_bus_responder
//  Description : Randomized self-checking bench. A transaction-level model
//                (queue of granted fetches, each tagged with its grant cycle)
//                predicts grant, SRAM strobe, response data/order and counts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_instr_bus_responder;

  localparam logic [31:0] c_BASE = 32'h0010_0000;
  localparam logic [31:0] c_SIZE = 32'h0001_0000;
  localparam int          c_MAX  = 2;
  localparam int          c_AW   = 14;
  localparam int          c_CYCLES = 4000;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              instr_req_i;
  logic [31:0]       instr_addr_i;
  logic              instr_gnt_o;
  logic              instr_rvalid_o;
  logic [31:0]       instr_rdata_o;
  logic              instr_err_o;
  logic              gnt_stall_i;
  logic              rsp_stall_i;
  logic              mem_req_o;
  logic [c_AW-1:0]   mem_addr_o;
  logic [31:0]       mem_rdata_i;
  logic [2:0]        outstanding_o;
  logic              busy_o;

  ibex_instr_bus_responder #(
    .AddrBase       (c_BASE),
    .AddrSize       (c_SIZE),
    .MaxOutstanding (c_MAX)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .instr_err_o    (instr_err_o),
    .gnt_stall_i    (gnt_stall_i),
    .rsp_stall_i    (rsp_stall_i),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_rdata_i    (mem_rdata_i),
    .outstanding_o  (outstanding_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t        model_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cur_cyc = 0;
  logic        prev_mreq;
  logic [c_AW-1:0] prev_maddr;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cur_cyc);
    end
  endtask

  // SRAM contents: a fixed scramble of the word index
  function automatic logic [31:0] mem_f(input logic [31:0] idx);
    return (idx * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit is_legal(input logic [31:0] a);
    longint la = longint'(a);
    return (la >= longint'(c_BASE)) && (la < longint'(c_BASE) + longint'(c_SIZE))
           && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] pick_addr();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 9))
      0:       return c_BASE + c_SIZE - 32'd4;
      1:       return c_BASE + c_SIZE;
      2:       return c_BASE - 32'd4;
      3:       return c_BASE;
      4:       return c_BASE + ((r % c_SIZE) | 32'd2);
      5:       return r;
      default: return c_BASE + ((r % c_SIZE) & ~32'd3);
    endcase
  endfunction

  initial begin
    int phase;
    bit exp_gnt, exp_rv, exp_mreq, legal;
    rsp_t e;
    rst_i = 1'b1; instr_req_i = 1'b0; instr_addr_i = 32'h0;
    gnt_stall_i = 1'b0; rsp_stall_i = 1'b0; mem_rdata_i = 32'h0;
    prev_mreq = 1'b0; prev_maddr = '0;
    for (int cyc = 0; cyc < c_CYCLES; cyc++) begin
      @(posedge clk_i);
      #1;
      cur_cyc = cyc;
      phase   = (cyc / 400) % 4;
      rst_i        = (cyc < 3) || ($urandom_range(0, 79) == 0);
      instr_req_i  = ($urandom_range(0, 9) != 0);
      instr_addr_i = pick_addr();
      case (phase)
        0: begin gnt_stall_i = 1'b0; rsp_stall_i = 1'b0; end
        1: begin gnt_stall_i = 1'b0; rsp_stall_i = ($urandom_range(0, 9) < 7); end
        2: begin gnt_stall_i = ($urandom_range(0, 4) == 0); rsp_stall_i = ($urandom_range(0, 4) == 0); end
        default: begin gnt_stall_i = $urandom_range(0, 1) == 1; rsp_stall_i = $urandom_range(0, 1) == 1; end
      endcase
      mem_rdata_i = prev_mreq ? mem_f(32'(prev_maddr)) : $urandom;
      #4;
      if (rst_i) begin
        check("rst_gnt",    32'(instr_gnt_o),    32'd0);
        check("rst_rvalid", 32'(instr_rvalid_o), 32'd0);
        check("rst_rdata",  instr_rdata_o,       32'd0);
        check("rst_err",    32'(instr_err_o),    32'd0);
        check("rst_mreq",   32'(mem_req_o),      32'd0);
        check("rst_maddr",  32'(mem_addr_o),     32'd0);
        check("rst_outst",  32'(outstanding_o),  32'd0);
        check("rst_busy",   32'(busy_o),         32'd0);
        model_q.delete();
      end else begin
        legal   = is_legal(instr_addr_i);
        exp_gnt = instr_req_i && !gnt_stall_i && (model_q.size() < c_MAX);
        check("gnt",   32'(instr_gnt_o),   32'(exp_gnt));
        check("outst", 32'(outstanding_o), 32'(model_q.size()));
        check("busy",  32'(busy_o),        32'(model_q.size() != 0));
        exp_rv = (model_q.size() > 0) && (model_q[0].cyc < cyc) && !rsp_stall_i;
        check("rvalid", 32'(instr_rvalid_o), 32'(exp_rv));
        if (exp_rv) begin
          e = model_q.pop_front();
          check("rdata", instr_rdata_o,     e.data);
          check("err",   32'(instr_err_o),  32'(e.err));
        end else begin
          check("idle_rdata", instr_rdata_o,    32'd0);
          check("idle_err",   32'(instr_err_o), 32'd0);
        end
        exp_mreq = exp_gnt && legal;
        check("mreq", 32'(mem_req_o), 32'(exp_mreq));
        if (exp_mreq)
          check("maddr", 32'(mem_addr_o), (instr_addr_i - c_BASE) >> 2);
        if (exp_gnt) begin
          e.cyc  = cyc;
          e.err  = !legal;
          e.data = legal ? mem_f((instr_addr_i - c_BASE) >> 2) : 32'h0;
          model_q.push_back(e);
        end
      end
      prev_mreq  = mem_req_o;
      prev_maddr = mem_addr_o;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
